// File: rtl/serial_subtractor_16.sv
// serial_subtractor_16: bit-serial 16-bit subtractor, LSB first; define SUB_OVERFLOW_EN to add the signed overflow output ov
module serial_subtractor_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y,
  output logic        borrow_out,
  output logic        busy,
  output logic        done
`ifdef SUB_OVERFLOW_EN
  ,output logic       ov
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d, b_q, b_d, r_q, r_d, y_q, y_d;
  logic        br_q, br_d, bo_q, bo_d, busy_q, busy_d, done_q, done_d;
  logic        dif, br_n;
`ifdef SUB_OVERFLOW_EN
  logic        a15_q, a15_d, b15_q, b15_d, ov_q, ov_d;
  assign ov = ov_q;
`endif
  assign y          = y_q;
  assign borrow_out = bo_q;
  assign busy       = busy_q;
  assign done       = done_q;
  // next-state: capture in IDLE, one full-subtractor bit per SHIFT cycle, publish on the 16th
  always_comb begin
    dif     = a_q[0] ^ b_q[0] ^ br_q;
    br_n    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    y_d     = y_q;
    bo_d    = bo_q;
`ifdef SUB_OVERFLOW_EN
    a15_d   = a15_q;
    b15_d   = b15_q;
    ov_d    = ov_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        br_d    = 1'b0;
        cnt_d   = 4'd0;
        state_d = SHIFT;
`ifdef SUB_OVERFLOW_EN
        a15_d   = a[15];
        b15_d   = b[15];
`endif
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {dif, r_q[15:1]};
        br_d  = br_n;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          y_d     = {dif, r_q[15:1]};
          bo_d    = br_n;
          state_d = DONE;
`ifdef SUB_OVERFLOW_EN
          ov_d    = (a15_q != b15_q) && (dif != a15_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  // state and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      y_q     <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a15_q   <= 1'b0;
      b15_q   <= 1'b0;
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      y_q     <= y_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB_OVERFLOW_EN
      a15_q   <= a15_d;
      b15_q   <= b15_d;
      ov_q    <= ov_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_subtractor_16.sv
// tb_serial_subtractor_16: scoreboard bench with randomized operands and start noise during SHIFT
module tb_serial_subtractor_16;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] a = '0, b = '0, y;
  logic        borrow_out, busy, done, ov_w;
  int          tests = 0, fails = 0;
  typedef struct packed {logic [15:0] y; logic bo; logic ov;} exp_t;
  exp_t q[$];
  exp_t e_m;
  logic [15:0] last_y;

  serial_subtractor_16 dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y(y),
    .borrow_out(borrow_out), .busy(busy), .done(done)
`ifdef SUB_OVERFLOW_EN
    ,.ov(ov_w)
`endif
  );
`ifndef SUB_OVERFLOW_EN
  assign ov_w = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] z);
    exp_t r;
    int   diff;
    diff = int'(x) - int'(z);
    r.y  = diff[15:0];
    r.bo = x < z;
    r.ov = (x[15] != z[15]) && (r.y[15] != x[15]);
    return r;
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e_m = q.pop_front();
        chk("y", y, e_m.y);
        chk("borrow_out", borrow_out, e_m.bo);
`ifdef SUB_OVERFLOW_EN
        chk("ov", ov_w, e_m.ov);
`endif
      end
    end
  end

  task automatic op(input logic [15:0] x, input logic [15:0] z, input bit noise);
    int n;
    exp_t r;
    @(negedge clk);
    a = x; b = z; start = 1'b1;
    r = model(x, z);
    q.push_back(r);
    last_y = r.y;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 25) begin
      if (noise) begin
        a = 16'($urandom); b = 16'($urandom); start = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency_edges", n, 17);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    repeat (2) @(negedge clk);
    chk("y_hold", y, last_y);
  endtask

  initial begin
    #1;
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bo", borrow_out, 0);
    chk("rst_ov", ov_w, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op(16'd6000, 16'd5000, 0);
    op(16'd5000, 16'd6000, 0);
    op(16'h0000, 16'h0001, 0);
    op(16'h1234, 16'h1234, 0);
    op(16'd6003, 16'd5004, 1);
    op(16'h8000, 16'h0001, 0);
    op(16'h0005, 16'h0003, 0);
    op(16'h7FFF, 16'hFFFF, 0);
    for (int i = 0; i < 20; i++) op(16'($urandom), 16'($urandom), 1'($urandom));
    @(negedge clk);
    a = 16'd100; b = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_y", y, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bo", borrow_out, 0);
    chk("abort_ov", ov_w, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_idle_y", y, 0);
    op(16'd10, 16'd3, 0);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
